serial_mult_seq: RTL and testbench



---
 rtl/serial_mult_seq_if.sv | 33 +++
 rtl/serial_mult_seq.sv | 114 +++++++++++
 tb/tb_serial_mult_seq.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_mult_seq_if.sv
// Operand and product valid/ready channels between a client and serial_mult_seq.
// The client holds the master view and the sequencer holds the slave view.
interface serial_mult_seq_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_p
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_p
  );
endinterface

// File: rtl/serial_mult_seq.sv
// Sequencer for the bit-serial multiplier core: feeds the multiplier LSB first for
// 2*WIDTH cycles and collects the serial product into a parallel result.
//
// state | meaning
// FLUSH | mul_x=0 for 2*WIDTH cycles so unknown core residue drains out
// IDLE  | in_ready=1, waiting for an operand pair
// RUN   | 2*WIDTH cycles driving b_reg bits, shifting mul_p into p_shift
// DONE  | out_valid=1, product held until out_ready
module serial_mult_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  serial_mult_seq_if.slave hs,
  output logic [WIDTH-1:0] mul_a,
  output logic             mul_x,
  input  logic             mul_p,
  output logic             busy
);
  localparam int PW = 2 * WIDTH;
  localparam int KW = $clog2(PW);
  localparam logic [KW-1:0] K_LAST = KW'(PW - 1);

  typedef enum logic [1:0] {
    S_FLUSH,
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [KW-1:0]    k;
  logic [KW-1:0]    k_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [PW-1:0]    b_ext;
  logic [PW-1:0]    p_shift;

  // Zero-extending b lets the next multiplier bit be looked up with the full
  // counter; the upper half supplies the zero bits that drain the core.
  assign b_ext  = {{WIDTH{1'b0}}, b_reg};
  assign k_next = k + 1'b1;

  assign mul_a    = a_reg;
  assign hs.out_p = p_shift;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_FLUSH;
      k            <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      p_shift      <= '0;
      hs.in_ready  <= 1'b0;
      hs.out_valid <= 1'b0;
      mul_x        <= 1'b0;
      busy         <= 1'b1;
    end else begin
      case (state)
        S_FLUSH: begin
          if (k == K_LAST) begin
            state       <= S_IDLE;
            k           <= '0;
            hs.in_ready <= 1'b1;
            busy        <= 1'b0;
          end else begin
            k <= k_next;
          end
        end

        S_IDLE: begin
          if (hs.in_valid && hs.in_ready) begin
            state       <= S_RUN;
            k           <= '0;
            a_reg       <= hs.in_a;
            b_reg       <= hs.in_b;
            p_shift     <= '0;
            hs.in_ready <= 1'b0;
            busy        <= 1'b1;
            mul_x       <= hs.in_b[0];
          end
        end

        S_RUN: begin
          p_shift <= {mul_p, p_shift[PW-1:1]};
          if (k == K_LAST) begin
            state        <= S_DONE;
            k            <= '0;
            hs.out_valid <= 1'b1;
            busy         <= 1'b0;
            mul_x        <= 1'b0;
          end else begin
            k     <= k_next;
            mul_x <= b_ext[k_next];
          end
        end

        S_DONE: begin
          if (hs.out_valid && hs.out_ready) begin
            state        <= S_IDLE;
            hs.out_valid <= 1'b0;
            hs.in_ready  <= 1'b1;
          end
        end

        default: begin
          state <= S_FLUSH;
          k     <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_mult_seq.sv
// Bench for serial_mult_seq: a behavioural bit-serial core on the shared clock,
// random and directed operands checked against plain a*b.
module tb_serial_mult_seq;
  localparam int WIDTH = 16;
  localparam int PW    = 2 * WIDTH;
  localparam int LAT   = PW;      // edges from acceptance to out_valid seen high
  localparam int SPACE = PW + 2;  // result spacing with both handshakes tied high

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] mul_a;
  logic             mul_x;
  logic             mul_p;
  logic             busy;

  serial_mult_seq_if #(.WIDTH(WIDTH)) hs ();

  serial_mult_seq #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .hs    (hs.slave),
    .mul_a (mul_a),
    .mul_x (mul_x),
    .mul_p (mul_p),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  // Core model: serial-parallel accumulator, product bit is the LSB of acc+a*x.
  // core_poison loads random residue so the flush is actually exercised.
  logic             core_poison = 1'b1;
  logic [WIDTH-1:0] core_acc;
  logic [WIDTH:0]   core_sum;
  assign core_sum = {1'b0, core_acc} + (mul_x ? {1'b0, mul_a} : '0);
  assign mul_p    = core_sum[0];
  always @(posedge clock) begin
    if (core_poison) core_acc <= WIDTH'($urandom);
    else             core_acc <= core_sum[WIDTH:1];
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_flush(input string tag);
    int n   = 0;
    int bad = 0;
    while (n < 200) begin
      @(negedge clock);
      n++;
      if (hs.in_ready === 1'b1) break;
      if (mul_x !== 1'b0 || busy !== 1'b1 || hs.out_valid !== 1'b0) bad++;
    end
    check({tag, "_len"}, n, PW);
    check({tag, "_bad"}, bad, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    while (hs.in_ready !== 1'b1 && w < 200) begin
      @(negedge clock);
      w++;
    end
    if (w >= 200) check({tag, "_rdy_timeout"}, w, 0);
  endtask

  // One transaction; hold = cycles of out_ready low after out_valid, early = out_ready high from the start.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int hold, input bit early);
    logic [PW-1:0] p;
    logic [PW-1:0] exp_p;
    int lat = 0;
    int bp_bad = 0;
    exp_p = PW'(a) * PW'(b);
    wait_ready(tag);
    hs.in_valid  = 1'b1;
    hs.in_a      = a;
    hs.in_b      = b;
    hs.out_ready = early;
    @(negedge clock);
    hs.in_valid = 1'b0;
    hs.in_a     = WIDTH'($urandom);
    hs.in_b     = WIDTH'($urandom);
    check({tag, "_mula"}, mul_a, a);
    check({tag, "_mulx0"}, mul_x, b[0]);
    while (hs.out_valid !== 1'b1 && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    p = hs.out_p;
    check({tag, "_lat"}, lat, LAT);
    check({tag, "_p"}, p, exp_p);
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        hs.in_valid = 1'b1;
        hs.in_a     = WIDTH'($urandom);
        hs.in_b     = WIDTH'($urandom);
        @(negedge clock);
        if (hs.out_p !== p || hs.in_ready !== 1'b0 || hs.out_valid !== 1'b1) bp_bad++;
      end
      if (hold > 0) check({tag, "_hold"}, bp_bad, 0);
      hs.in_valid  = 1'b0;
      hs.out_ready = 1'b1;
    end
    @(negedge clock);
    hs.out_ready = 1'b0;
    check({tag, "_post"}, {hs.out_valid, hs.in_ready, busy}, 3'b010);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] expq[$];
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [PW-1:0] exp_p;
    int t, last_t, got_n, sent, w;

    hs.in_valid  = 1'b1;   // must be ignored during reset and flush
    hs.out_ready = 1'b1;
    hs.in_a      = 16'h1111;
    hs.in_b      = 16'h2222;
    repeat (3) @(negedge clock);
    check("rst_state", {hs.in_ready, hs.out_valid, mul_x, busy}, 4'b0001);
    check("rst_mula", mul_a, 0);
    check("rst_outp", hs.out_p, 0);

    reset       = 1'b0;
    core_poison = 1'b0;
    wait_flush("flush");
    hs.in_valid  = 1'b0;
    hs.out_ready = 1'b0;
    @(negedge clock);

    run_op("basic", 16'h0003, 16'h0005, 0, 1'b0);
    run_op("b1234", 16'h1234, 16'h00FF, 2, 1'b0);
    run_op("maxop", 16'hFFFF, 16'hFFFF, 10, 1'b0);
    run_op("one",   16'h0001, 16'h0001, 0, 1'b1);
    run_op("zero_a", 16'h0000, 16'hBEEF, 0, 1'b1);
    run_op("zero_b", 16'h1234, 16'h0000, 1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_op($sformatf("rnd%0d", i), WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(0, 5)),
             1'(i % 2));
    end

    // Reset at k=7 of a 0xFFFF*0xFFFF run leaves residue in the core.
    wait_ready("midrun");
    hs.in_valid = 1'b1;
    hs.in_a     = 16'hFFFF;
    hs.in_b     = 16'hFFFF;
    hs.out_ready = 1'b1;
    @(negedge clock);
    hs.in_valid = 1'b0;
    repeat (7) @(negedge clock);
    check("midrun_busy", {busy, hs.out_valid}, 2'b10);
    reset = 1'b1;
    @(negedge clock);
    check("midrun_rst", {hs.out_valid, hs.in_ready, busy}, 3'b001);
    reset = 1'b0;
    wait_flush("reflush");
    hs.out_ready = 1'b0;
    run_op("after_rst", 16'h00AA, 16'h0055, 0, 1'b0);

    // Reset while a product is pending in DONE discards it.
    wait_ready("done_rst");
    hs.in_valid = 1'b1;
    hs.in_a     = 16'h00F0;
    hs.in_b     = 16'h0F0F;
    @(negedge clock);
    hs.in_valid = 1'b0;
    w = 0;
    while (hs.out_valid !== 1'b1 && w < 200) begin
      @(negedge clock);
      w++;
    end
    check("done_rst_lat", w, LAT);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("done_rst_drop", {hs.out_valid, hs.in_ready, busy}, 3'b001);
    wait_flush("done_flush");
    run_op("after_done_rst", 16'hABCD, 16'h1357, 0, 1'b1);

    // Back-to-back: both handshakes held high, 8 random pairs.
    hs.out_ready = 1'b1;
    t = 0;
    last_t = -1;
    got_n = 0;
    sent = 0;
    while (got_n < 8 && t < 1000) begin
      if (hs.out_valid === 1'b1) begin
        if (expq.size() == 0) begin
          check("b2b_unexpected", 1, 0);
        end else begin
          exp_p = expq.pop_front();
          check($sformatf("b2b_p%0d", got_n), hs.out_p, exp_p);
        end
        if (last_t >= 0) check($sformatf("b2b_gap%0d", got_n), t - last_t, SPACE);
        last_t = t;
        got_n++;
      end
      if (hs.in_ready === 1'b1 && sent < 8) begin
        ra = WIDTH'($urandom);
        rb = WIDTH'($urandom);
        if (sent == 3) ra = '0;
        expq.push_back(PW'(ra) * PW'(rb));
        hs.in_a     = ra;
        hs.in_b     = rb;
        hs.in_valid = 1'b1;
        sent++;
      end else if (hs.in_ready === 1'b1) begin
        hs.in_valid = 1'b0;
      end
      @(negedge clock);
      t++;
    end
    check("b2b_count", got_n, 8);
    hs.in_valid  = 1'b0;
    hs.out_ready = 1'b0;
    repeat (2) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
